// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-master memory bus arbiter.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDbg    = 2'd2,
        StDone   = 2'd3
    } state_e;

    localparam int unsigned DEBUG_ADDR_DEFAULT = 256;
    localparam logic [31:0] TIMEOUT_DATA       = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-way round-robin picker; remembers the last served master and
// favours the other one on a tie.
module mem_arbiter_rr
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic       winner
);

    logic last_q, last_d;

    // Pointer moves only when a transaction retires.
    always_comb begin
        last_d = last_q;
        if (update) begin
            last_d = served;
        end
    end

    // Master 1 counts as last served out of reset so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // Lone requester wins; on a tie the master not served last wins.
    always_comb begin
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_q;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master / one-slave arbiter and sequencer for the word-addressed memory
// bus. Owns the debug latch register at DEBUG_ADDR.
// Optional access timeout enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned AW         = 30,
    parameter int unsigned DW         = 32,
    parameter int unsigned DEBUG_ADDR = DEBUG_ADDR_DEFAULT,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic          s_re,
    output logic          s_we,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    input  logic          s_ready,
    output logic [DW-1:0] debug_q,
    output logic          grant,
    output logic          busy,
    output logic          err
);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          s_re_q, s_re_d;
    logic          s_we_q, s_we_d;
    logic          m0_ack_q, m0_ack_d;
    logic          m1_ack_q, m1_ack_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic [DW-1:0] debug_reg_q, debug_reg_d;

    logic          winner;
    logic          rr_update;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          finish;
    logic [DW-1:0] fin_rdata;

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    mem_arbiter_rr u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    ({m1_req, m0_req}),
        .update (rr_update),
        .served (grant_q),
        .winner (winner)
    );

    // Mux the winning master's request fields.
    always_comb begin
        sel_we    = winner ? m1_we    : m0_we;
        sel_addr  = winner ? m1_addr  : m0_addr;
        sel_wdata = winner ? m1_wdata : m0_wdata;
    end

    // Next-state logic; acks and rdata are set only on the edge into DONE, so
    // their zero defaults turn them into one-cycle pulses.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        s_re_d      = s_re_q;
        s_we_d      = s_we_q;
        debug_reg_d = debug_reg_q;
        m0_ack_d    = 1'b0;
        m1_ack_d    = 1'b0;
        m0_rdata_d  = '0;
        m1_rdata_d  = '0;
        rr_update   = 1'b0;
        finish      = 1'b0;
        fin_rdata   = '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    grant_d = winner;
                    we_d    = sel_we;
                    addr_d  = sel_addr;
                    wdata_d = sel_wdata;
                    if (sel_addr == AW'(DEBUG_ADDR)) begin
                        state_d = StDbg;
                    end else begin
                        state_d = StAccess;
                        s_re_d  = ~sel_we;
                        s_we_d  = sel_we;
`ifdef MEM_ARBITER_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            StAccess: begin
                if (s_ready) begin
                    finish    = 1'b1;
                    fin_rdata = we_q ? '0 : s_rdata;
`ifdef MEM_ARBITER_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    finish    = 1'b1;
                    fin_rdata = DW'(TIMEOUT_DATA);
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDbg: begin
                finish = 1'b1;
                if (we_q) begin
                    debug_reg_d = wdata_q;
                end else begin
                    fin_rdata = debug_reg_q;
                end
            end
            StDone: begin
                rr_update = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (finish) begin
            state_d    = StDone;
            s_re_d     = 1'b0;
            s_we_d     = 1'b0;
            m0_ack_d   = ~grant_q;
            m1_ack_d   = grant_q;
            m0_rdata_d = grant_q ? '0 : fin_rdata;
            m1_rdata_d = grant_q ? fin_rdata : '0;
        end
    end

    // State and registered outputs; reset drops any in-flight transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            grant_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            s_re_q      <= 1'b0;
            s_we_q      <= 1'b0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            debug_reg_q <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            s_re_q      <= s_re_d;
            s_we_q      <= s_we_d;
            m0_ack_q    <= m0_ack_d;
            m1_ack_q    <= m1_ack_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            debug_reg_q <= debug_reg_d;
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign s_re     = s_re_q;
    assign s_we     = s_we_q;
    assign s_addr   = addr_q;
    assign s_wdata  = wdata_q;
    assign debug_q  = debug_reg_q;
    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);
`ifdef MEM_ARBITER_TIMEOUT_EN
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_ack;
    logic [29:0] m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [29:0] m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        s_re, s_we, s_ready;
    logic [29:0] s_addr;
    logic [31:0] s_wdata, s_rdata, debug_q;
    logic        grant, busy, err;

    int          n_checks;
    int          n_errors;
    int          re_cnt;
    int          we_cnt;
    logic [29:0] re_addr;
    int          cyc;
    int          acks;

    mem_arbiter #(
        .AW         (30),
        .DW         (32),
        .DEBUG_ADDR (256),
        .TIMEOUT    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .s_re     (s_re),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .s_ready  (s_ready),
        .debug_q  (debug_q),
        .grant    (grant),
        .busy     (busy),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Waits on negedges for any ack; s_ready is raised at negedge number ready_at.
    task automatic wait_ack(input string tag, input int budget, input int ready_at,
                            output int n);
        re_cnt = 0;
        we_cnt = 0;
        n      = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (s_re) begin
                re_cnt++;
                re_addr = s_addr;
            end
            if (s_we) we_cnt++;
            if (n == ready_at) s_ready = 1'b1;
            if (m0_ack || m1_ack) break;
        end
        check(tag, 32'(m0_ack | m1_ack), 32'd1);
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b0;
        m0_req   = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req   = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        s_ready  = 1'b1;
        s_rdata  = 32'h1234_5678;

        // Reset state
        @(negedge clk);
        check("rst_busy",  32'(busy),   32'd0);
        check("rst_grant", 32'(grant),  32'd0);
        check("rst_ack",   32'({m1_ack, m0_ack}), 32'd0);
        check("rst_m0rd",  m0_rdata,    32'd0);
        check("rst_m1rd",  m1_rdata,    32'd0);
        check("rst_strb",  32'({s_re, s_we}), 32'd0);
        check("rst_dbg",   debug_q,     32'd0);
        check("rst_err",   32'(err),    32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // m0 single read with s_ready high
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h10;
        wait_ack("rd_ack", 10, -1, cyc);
        check("rd_lat",   32'(cyc),     32'd2);
        check("rd_m0ack", 32'(m0_ack),  32'd1);
        check("rd_data",  m0_rdata,     32'h1234_5678);
        check("rd_recnt", 32'(re_cnt),  32'd1);
        check("rd_addr",  32'(re_addr), 32'h10);
        check("rd_wecnt", 32'(we_cnt),  32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        check("rd_ackoff", 32'(m0_ack), 32'd0);
        check("rd_idle",   32'(busy),   32'd0);

        // Both masters request continuously: 0,1,0,1 at one per 3 cycles
        do_reset();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h20;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h24;
        for (int i = 0; i < 4; i++) begin
            wait_ack("alt_ack", 10, -1, cyc);
            check("alt_lat",   32'(cyc),    32'd2);
            check("alt_m0",    32'(m0_ack), 32'(i % 2 == 0));
            check("alt_m1",    32'(m1_ack), 32'(i % 2 == 1));
            check("alt_grant", 32'(grant),  32'(i % 2));
            @(negedge clk);
            check("alt_pulse", 32'(m0_ack | m1_ack), 32'd0);
            if (i == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
        end
        repeat (2) @(negedge clk);

        // Debug register via m1: write then read, slave untouched
        s_rdata  = 32'h1111_2222;
        m1_req   = 1'b1; m1_we = 1'b1; m1_addr = 30'd256; m1_wdata = 32'hCAFE_F00D;
        wait_ack("dbgw_ack", 10, -1, cyc);
        check("dbgw_m1",   32'(m1_ack),           32'd1);
        check("dbgw_rd",   m1_rdata,              32'd0);
        check("dbgw_strb", 32'(re_cnt + we_cnt),  32'd0);
        m1_req = 1'b0;
        @(negedge clk);
        check("dbg_q", debug_q, 32'hCAFE_F00D);
        m1_req = 1'b1; m1_we = 1'b0;
        wait_ack("dbgr_ack", 10, -1, cyc);
        check("dbgr_lat",  32'(cyc),              32'd2);
        check("dbgr_data", m1_rdata,              32'hCAFE_F00D);
        check("dbgr_strb", 32'(re_cnt + we_cnt),  32'd0);
        m1_req = 1'b0;
        @(negedge clk);

        // Write with s_ready low for 5 ACCESS cycles
        s_ready = 1'b0;
        m0_req  = 1'b1; m0_we = 1'b1; m0_addr = 30'h80; m0_wdata = 32'h0BAD_F00D;
        wait_ack("ws_ack", 20, 6, cyc);
        check("ws_lat",   32'(cyc),    32'd7);
        check("ws_wecnt", 32'(we_cnt), 32'd6);
        check("ws_recnt", 32'(re_cnt), 32'd0);
        check("ws_m0",    32'(m0_ack), 32'd1);
        check("ws_rd",    m0_rdata,    32'd0);
        check("ws_wdata", s_wdata,     32'h0BAD_F00D);
        m0_req = 1'b0;
        @(negedge clk);

        // Reset during ACCESS, then a pending m1 read is served
        s_ready = 1'b0;
        m0_req  = 1'b1; m0_we = 1'b1; m0_addr = 30'h20; m0_wdata = 32'h55;
        @(negedge clk);
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 30'h30;
        check("ra_we", 32'(s_we), 32'd1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("ra_we0",   32'(s_we),   32'd0);
        check("ra_busy",  32'(busy),   32'd0);
        check("ra_dbg",   debug_q,     32'd0);
        check("ra_addr",  32'(s_addr), 32'd0);
        m0_req = 1'b0;
        acks = 0;
        repeat (2) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        check("ra_noack", 32'(acks), 32'd0);
        rst     = 1'b1;
        s_ready = 1'b1;
        s_rdata = 32'hA5A5_0001;
        wait_ack("ra_ack", 10, -1, cyc);
        check("ra_lat",   32'(cyc),     32'd2);
        check("ra_m1",    32'(m1_ack),  32'd1);
        check("ra_m0",    32'(m0_ack),  32'd0);
        check("ra_grant", 32'(grant),   32'd1);
        check("ra_data",  m1_rdata,     32'hA5A5_0001);
        check("ra_raddr", 32'(re_addr), 32'h30);
        m1_req = 1'b0;
        @(negedge clk);

        // Slave stuck not-ready
        s_ready = 1'b0;
        s_rdata = 32'h1111_1111;
        m0_req  = 1'b1; m0_we = 1'b0; m0_addr = 30'h40;
`ifdef MEM_ARBITER_TIMEOUT_EN
        wait_ack("to_ack", 20, -1, cyc);
        check("to_lat",   32'(cyc),    32'd5);
        check("to_err",   32'(err),    32'd1);
        check("to_data",  m0_rdata,    32'hDEAD_BEEF);
        check("to_recnt", 32'(re_cnt), 32'd4);
        check("to_strb",  32'(s_re),   32'd0);
        m0_req = 1'b0;
        @(negedge clk);
        check("to_errof", 32'(err),    32'd0);
`else
        acks = 0;
        repeat (15) begin
            @(negedge clk);
            if (m0_ack || m1_ack) acks++;
        end
        check("nt_noack", 32'(acks), 32'd0);
        check("nt_busy",  32'(busy), 32'd1);
        check("nt_re",    32'(s_re), 32'd1);
        check("nt_err",   32'(err),  32'd0);
        wait_ack("nt_ack", 10, 1, cyc);
        check("nt_lat",   32'(cyc),  32'd2);
        check("nt_data",  m0_rdata,  32'h1111_1111);
        check("nt_err2",  32'(err),  32'd0);
        m0_req = 1'b0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
